// File: rtl/halt_pkg.sv
// halt_pkg: shared state encoding and drain-length default for the halt controller
package halt_pkg;
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_t;
    localparam int DRAIN_CYCLES_DEF = 3;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: enabled up-counter with async clear that sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            q <= '0;
        else if (en && q != '1)
            q <= q + 1'b1;
endmodule

// File: rtl/halt_ctrl.sv
// halt_ctrl: accepts an ID-stage HLT, drains older instructions, then raises sticky hlt with PC+1
module halt_ctrl
    import halt_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hlt_dec,
    input  logic             id_valid,
    input  logic             stall_in,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [PC_W-1:0]  id_pc_plus_1,
    output logic             fetch_stop,
    output logic             hlt,
    output logic [PC_W-1:0]  pc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
);
    state_t     state;
    logic [3:0] drain_cnt;
    logic       accept;
    assign accept     = (state == RUN) && hlt_dec && id_valid && !stall_in && !flush;
    // combinational so the instruction fetched alongside the accepted HLT never lands in IF/ID
    assign fetch_stop = accept || (state != RUN);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            hlt       <= 1'b0;
            pc        <= '0;
            drain_cnt <= '0;
        end else if (accept) begin
            state     <= DRAIN;
            pc        <= id_pc_plus_1;
            drain_cnt <= 4'(DRAIN_CYCLES - 1);
        end else if (state == DRAIN) begin
            if (drain_cnt == 4'd0) begin
                state <= HALTED;
                hlt   <= 1'b1;
            end else
                drain_cnt <= drain_cnt - 4'd1;
        end
    end
    sat_counter #(.WIDTH(CNT_W)) u_cycle (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != HALTED),
        .q     (cycle_cnt)
    );
    sat_counter #(.WIDTH(CNT_W)) u_retired (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wb_valid && state != HALTED),
        .q     (retired_cnt)
    );
endmodule

// File: tb/tb_halt_ctrl.sv
// tb_halt_ctrl: directed and randomized checks of halt_ctrl against a cycle-level reference model
module tb_halt_ctrl;
    localparam int PC_W = 16;
    localparam int DC   = 3;
    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;

    logic clk = 0, rst_n = 0;
    logic hlt_dec = 0, id_valid = 0, stall_in = 0, flush = 0, wb_valid = 0;
    logic [PC_W-1:0] id_pc_plus_1 = '0;
    logic fetch_stop, hlt;
    logic [PC_W-1:0] pc;
    logic [31:0] cycle_cnt, retired_cnt;
    logic s_fs, s_hlt;
    logic [PC_W-1:0] s_pc;
    logic [3:0] s_cyc, s_ret;

    int checks = 0, errors = 0;

    bit     m_halted;
    int     m_left;
    logic [PC_W-1:0] m_pc;
    longint m_cyc, m_ret, m_cyc4, m_ret4;

    always #5 clk = ~clk;

    halt_ctrl #(.PC_W(PC_W), .CNT_W(32), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .hlt_dec(hlt_dec), .id_valid(id_valid),
        .stall_in(stall_in), .flush(flush), .wb_valid(wb_valid),
        .id_pc_plus_1(id_pc_plus_1), .fetch_stop(fetch_stop), .hlt(hlt),
        .pc(pc), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
    );

    halt_ctrl #(.PC_W(PC_W), .CNT_W(4), .DRAIN_CYCLES(DC)) dut_small (
        .clk(clk), .rst_n(rst_n), .hlt_dec(1'b0), .id_valid(1'b0),
        .stall_in(1'b0), .flush(1'b0), .wb_valid(wb_valid),
        .id_pc_plus_1(id_pc_plus_1), .fetch_stop(s_fs), .hlt(s_hlt),
        .pc(s_pc), .cycle_cnt(s_cyc), .retired_cnt(s_ret)
    );

    task automatic model_reset();
        m_halted = 0; m_left = 0; m_pc = '0;
        m_cyc = 0; m_ret = 0; m_cyc4 = 0; m_ret4 = 0;
    endtask

    task automatic idle_inputs();
        hlt_dec = 0; id_valid = 0; stall_in = 0; flush = 0; wb_valid = 0; id_pc_plus_1 = '0;
    endtask

    // one clock: sample fetch_stop before the edge, advance the model, settle after
    task automatic step(output logic fs, output logic fs_exp);
        bit acc;
        #2;
        acc = !m_halted && m_left == 0 && hlt_dec && id_valid && !stall_in && !flush;
        fs = fetch_stop;
        fs_exp = acc || m_left > 0 || m_halted;
        @(posedge clk);
        if (!m_halted) begin
            if (m_cyc < MAX32) m_cyc++;
            if (wb_valid && m_ret < MAX32) m_ret++;
        end
        if (m_cyc4 < 15) m_cyc4++;
        if (wb_valid && m_ret4 < 15) m_ret4++;
        if (acc) begin
            m_left = DC;
            m_pc = id_pc_plus_1;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_halted = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        model_reset();
        #2;
        rst_n = 1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({fetch_stop, hlt, pc, cycle_cnt, retired_cnt} !== '0) begin
            errors++;
            $display("FAIL reset: fs=%b hlt=%b pc=%h cyc=%0d ret=%0d required all 0",
                     fetch_stop, hlt, pc, cycle_cnt, retired_cnt);
        end
    endtask

    task automatic test_basic();
        logic fs, fse;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            wb_valid = 1'($urandom);
            step(fs, fse);
        end
        hlt_dec = 1; id_valid = 1; id_pc_plus_1 = 16'h0007; wb_valid = 0;
        step(fs, fse);
        checks++;
        if (fs !== 1'b1) begin errors++; $display("FAIL basic_fetch_stop: got %b want 1", fs); end
        idle_inputs();
        for (int e = 11; e <= 13; e++) begin
            checks++;
            if (hlt !== 1'b0) begin errors++; $display("FAIL basic_hlt_early edge %0d: got %b want 0", e - 1, hlt); end
            step(fs, fse);
        end
        checks++;
        if (hlt !== 1'b1) begin errors++; $display("FAIL basic_hlt: got %b want 1", hlt); end
        checks++;
        if (pc !== 16'h0007) begin errors++; $display("FAIL basic_pc: got %h want 0007", pc); end
        checks++;
        if (cycle_cnt !== 32'd13) begin errors++; $display("FAIL basic_cyc: got %0d want 13", cycle_cnt); end
        for (int i = 0; i < 20; i++) begin
            hlt_dec = 1'($urandom); id_valid = 1; wb_valid = 1'($urandom);
            step(fs, fse);
        end
        checks++;
        if (cycle_cnt !== 32'd13 || hlt !== 1'b1 || pc !== 16'h0007) begin
            errors++;
            $display("FAIL basic_frozen: cyc=%0d hlt=%b pc=%h want 13 1 0007", cycle_cnt, hlt, pc);
        end
        checks++;
        if (retired_cnt !== m_ret[31:0]) begin errors++; $display("FAIL basic_ret: got %0d want %0d", retired_cnt, m_ret); end
    endtask

    task automatic test_flush();
        logic fs, fse;
        do_reset();
        step(fs, fse); step(fs, fse);
        hlt_dec = 1; id_valid = 1; flush = 1; id_pc_plus_1 = 16'h0010;
        step(fs, fse);
        checks++;
        if (fs !== 1'b0) begin errors++; $display("FAIL flush_squash_fs: got %b want 0", fs); end
        flush = 0; id_pc_plus_1 = 16'h0020;
        step(fs, fse);
        checks++;
        if (fs !== 1'b1) begin errors++; $display("FAIL flush_accept_fs: got %b want 1", fs); end
        idle_inputs();
        repeat (3) step(fs, fse);
        checks++;
        if (hlt !== 1'b1 || pc !== 16'h0020) begin
            errors++; $display("FAIL flush_result: hlt=%b pc=%h want 1 0020", hlt, pc);
        end
    endtask

    task automatic test_stall();
        logic fs, fse;
        do_reset();
        step(fs, fse);
        hlt_dec = 1; id_valid = 1; id_pc_plus_1 = 16'h0042;
        for (int i = 0; i < 3; i++) begin
            stall_in = (i < 2);
            step(fs, fse);
            checks++;
            if (fs !== (i == 2)) begin errors++; $display("FAIL stall_fs cycle %0d: got %b want %b", i, fs, i == 2); end
        end
        idle_inputs();
        repeat (2) step(fs, fse);
        checks++;
        if (hlt !== 1'b0) begin errors++; $display("FAIL stall_hlt_early: got %b want 0", hlt); end
        step(fs, fse);
        checks++;
        if (hlt !== 1'b1 || pc !== 16'h0042) begin
            errors++; $display("FAIL stall_hlt: hlt=%b pc=%h want 1 0042", hlt, pc);
        end
    endtask

    task automatic test_retired();
        logic fs, fse;
        do_reset();
        wb_valid = 1;
        repeat (4) step(fs, fse);
        hlt_dec = 1; id_valid = 1; id_pc_plus_1 = 16'h0100;
        step(fs, fse);
        hlt_dec = 0; id_valid = 0;
        repeat (3) step(fs, fse);
        checks++;
        if (retired_cnt !== 32'd8 || hlt !== 1'b1) begin
            errors++; $display("FAIL retired_at_halt: ret=%0d hlt=%b want 8 1", retired_cnt, hlt);
        end
        repeat (4) step(fs, fse);
        checks++;
        if (retired_cnt !== 32'd8) begin errors++; $display("FAIL retired_after_halt: got %0d want 8", retired_cnt); end
    endtask

    task automatic test_saturation();
        logic fs, fse;
        do_reset();
        repeat (20) begin
            wb_valid = 1'($urandom);
            step(fs, fse);
        end
        checks++;
        if (s_cyc !== 4'hF) begin errors++; $display("FAIL sat_cyc: got %h want F", s_cyc); end
        checks++;
        if (s_ret !== 4'(m_ret4)) begin errors++; $display("FAIL sat_ret: got %0d want %0d", s_ret, m_ret4); end
        checks++;
        if (cycle_cnt !== 32'd20) begin errors++; $display("FAIL sat_wide_cyc: got %0d want 20", cycle_cnt); end
    endtask

    task automatic test_async_reset();
        logic fs, fse;
        do_reset();
        repeat (3) step(fs, fse);
        hlt_dec = 1; id_valid = 1; wb_valid = 1; id_pc_plus_1 = 16'h0055;
        step(fs, fse);
        idle_inputs();
        step(fs, fse);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({fetch_stop, hlt, pc, cycle_cnt, retired_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: fs=%b hlt=%b pc=%h cyc=%0d ret=%0d required all 0",
                     fetch_stop, hlt, pc, cycle_cnt, retired_cnt);
        end
        model_reset();
        #2;
        rst_n = 1;
        hlt_dec = 1; id_valid = 1; id_pc_plus_1 = 16'h0003;
        step(fs, fse);
        idle_inputs();
        repeat (2) step(fs, fse);
        checks++;
        if (hlt !== 1'b0) begin errors++; $display("FAIL async_hlt_early: got %b want 0", hlt); end
        step(fs, fse);
        checks++;
        if (hlt !== 1'b1 || pc !== 16'h0003 || cycle_cnt !== 32'd4) begin
            errors++; $display("FAIL async_rehalt: hlt=%b pc=%h cyc=%0d want 1 0003 4", hlt, pc, cycle_cnt);
        end
    endtask

    task automatic test_random();
        logic fs, fse;
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < 40; i++) begin
                hlt_dec = ($urandom_range(0, 5) == 0);
                id_valid = ($urandom_range(0, 3) != 0);
                stall_in = ($urandom_range(0, 3) == 0);
                flush = ($urandom_range(0, 4) == 0);
                wb_valid = 1'($urandom);
                id_pc_plus_1 = 16'($urandom);
                step(fs, fse);
                checks++;
                if (fs !== fse || hlt !== m_halted || pc !== m_pc || cycle_cnt !== m_cyc[31:0]
                    || retired_cnt !== m_ret[31:0] || s_cyc !== 4'(m_cyc4)) begin
                    errors++;
                    $display("FAIL random r%0d i%0d: fs=%b/%b hlt=%b/%b pc=%h/%h cyc=%0d/%0d ret=%0d/%0d scyc=%0d/%0d",
                             r, i, fs, fse, hlt, m_halted, pc, m_pc, cycle_cnt, m_cyc,
                             retired_cnt, m_ret, s_cyc, m_cyc4);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_flush();
        test_stall();
        test_retired();
        test_saturation();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/halt_ctrl.md
Name: halt_ctrl

Overview:
- Pipeline-side producer of the hlt/pc pair that the simulation bench watches on the cpu top level.
- Accepts a decoded HLT instruction in the ID stage and stops fetch, then waits while older instructions drain through EX/MEM/WB.
- After the drain it asserts a sticky halt and presents the HLT instruction's PC+1.
- Keeps free-running cycle and retired-instruction counters that freeze at halt, for end-of-run reporting.

Parameters:
- PC_W, 16, width of PC values.
- CNT_W, 32, width of the cycle and retired counters.
- DRAIN_CYCLES, 3, cycles between HLT acceptance and hlt assertion (EX, MEM, WB of older instructions); legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- hlt_dec  in  1  ID stage instruction decodes as HLT.
- id_valid  in  1  ID stage holds a valid, non-bubble instruction.
- stall_in  in  1  ID is held this cycle (load-use stall).
- flush  in  1  taken branch/jump in EX squashes IF and ID this cycle.
- wb_valid  in  1  a valid instruction retires in WB this cycle.
- id_pc_plus_1  in  PC_W  PC+1 of the ID-stage instruction.
- fetch_stop  out  1  freeze PC; IF/ID loads a bubble.
- hlt  out  1  sticky halt indication.
- pc  out  PC_W  captured PC+1 of the accepted HLT.
- cycle_cnt  out  CNT_W  cycles executed before halt.
- retired_cnt  out  CNT_W  instructions retired before halt.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- Reset (rst_n low, asynchronous, at any time including mid-drain):
  - state = RUN; hlt = 0; pc = 0; cycle_cnt = 0; retired_cnt = 0; drain counter = 0.
  - fetch_stop = 0 combinationally.
- FSM states: RUN, DRAIN, HALTED.
- accept = (state==RUN) & hlt_dec & id_valid & ~stall_in & ~flush.
  - An HLT under flush is squashed and never accepted.
  - An HLT under stall is held and re-evaluated every cycle.
- RUN → DRAIN on an accept edge:
  - pc <= id_pc_plus_1.
  - drain counter <= DRAIN_CYCLES-1.
- DRAIN:
  - If counter == 0: go to HALTED and set hlt <= 1.
  - Otherwise decrement the counter.
  - flush, stall_in and hlt_dec are ignored. Any branch older than the HLT resolved while the HLT was in ID.
- HALTED is absorbing; only reset leaves it. hlt stays 1, pc holds, and a second hlt_dec has no effect.
- Latency: hlt rises at the DRAIN_CYCLES-th rising edge after the accept edge. With the default, accept at edge N gives hlt high after edge N+3.
- fetch_stop = accept | (state != RUN). It is combinational so the instruction fetched in the accept cycle is not written into IF/ID.
- cycle_cnt:
  - Increments on every edge whose pre-edge state is RUN or DRAIN.
  - Frozen in HALTED.
  - Saturates at all-ones; no wrap.
- retired_cnt:
  - Increments on edges with wb_valid=1 and pre-edge state != HALTED.
  - Saturates at all-ones.
- Simultaneous events:
  - The accept edge may also carry wb_valid and is counted.
  - The final DRAIN edge counts wb_valid and the cycle.
- All outputs except fetch_stop are registered.

Decomposition:
- Package halt_pkg: FSM state encoding constants (RUN=2'b00, DRAIN=2'b01, HALTED=2'b10) and the DRAIN_CYCLES default.
- Sub-module sat_counter:
  - Parameter width; inputs clk, rst_n, en; output q.
  - Asynchronous active-low clear; saturating increment.
  - Instantiated twice (cycle_cnt, retired_cnt).
- FSM, drain counter and pc capture stay in halt_ctrl.

Test Plan:
- Basic halt:
  - Stimulus: reset released before edge 1; hlt_dec=id_valid=1, id_pc_plus_1=16'h0007 in the cycle before edge 10.
  - Response: fetch_stop=1 in that cycle; hlt=0 after edges 10–12; hlt=1 after edge 13; pc=16'h0007; cycle_cnt=13 and still 13 twenty cycles later.
- Flush squash:
  - Stimulus: hlt_dec with flush=1 and pc 16'h0010; next cycle hlt_dec with flush=0 and pc 16'h0020.
  - Response: first HLT ignored (state RUN, fetch_stop=0 during it); second accepted; final pc=16'h0020.
- Stall hold:
  - Stimulus: hlt_dec held 3 cycles with stall_in=1,1,0.
  - Response: accept only on the third cycle; hlt rises 3 edges later.
- Retired count:
  - Stimulus: wb_valid=1 on 5 RUN edges, 3 DRAIN edges, then 4 edges after halt.
  - Response: retired_cnt=8, unchanged after halt.
- Saturation:
  - Stimulus: CNT_W=4, no HLT for 20 cycles.
  - Response: cycle_cnt=4'hF held.
- Async reset mid-drain:
  - Stimulus: rst_n pulsed low between edges during DRAIN.
  - Response: hlt, pc, both counters and fetch_stop 0 immediately, without waiting for a clock edge; after release, a new HLT at 16'h0003 halts normally with pc=16'h0003.
